// File: rtl/rv_pipe_pkg.sv
// Shared constants for the uRV pipeline hazard controller.
// Stage indices follow pipeline order, from fetch (0) to writeback.
package rv_pipe_pkg;
  localparam int STAGE_F = 0;
  localparam int STAGE_D = 1;
  localparam int STAGE_X = 2;
  localparam int STAGE_W = 3;
  localparam int DEFAULT_CNT_WIDTH = 32;
endpackage

// File: rtl/rv_sat_counter.sv
// Event counter that saturates at all-ones instead of wrapping.
// A clear request takes priority over an increment in the same cycle.
module rv_sat_counter #(
  parameter int G_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [G_WIDTH-1:0] value_o
);

  logic [G_WIDTH-1:0] value_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      value_reg <= '0;
    end else if (inc_i && (value_reg != {G_WIDTH{1'b1}})) begin
      value_reg <= value_reg + 1'b1;
    end
  end

  assign value_o = value_reg;

endmodule

// File: rtl/rv_pipe_ctrl.sv
// Pipeline hazard controller: stage stall/kill, branch shadow, and load-use bubble.
// Outputs are combinational from the inputs and a small amount of history state.
module rv_pipe_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int G_NUM_STAGES   = 4,
  parameter int G_BRANCH_STAGE = STAGE_X,
  parameter int G_ILK_STAGE    = STAGE_D,
  parameter int G_LOAD_ILK     = 1,
  parameter int G_CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [G_NUM_STAGES-1:0] stall_req_i,
  input  logic                    branch_take_i,
  input  logic                    load_hazard_i,
  input  logic                    x_load_i,
  input  logic                    cnt_clear_i,
  output logic [G_NUM_STAGES-1:0] stall_o,
  output logic [G_NUM_STAGES-1:0] kill_o,
  output logic                    bubble_o,
  output logic [G_CNT_WIDTH-1:0]  cnt_stall_o,
  output logic [G_CNT_WIDTH-1:0]  cnt_branch_o,
  output logic [G_CNT_WIDTH-1:0]  cnt_ilk_o
);

  logic [G_BRANCH_STAGE-1:0] hist_reg;
  logic                      ilk_d0_reg;
  logic                      req_stall;
  logic                      ilk;
  logic                      hist_shift;
  logic                      branch_accept;

  assign req_stall = |stall_req_i;

  // Kill does not depend on the interlock, so feeding kill into ilk forms no loop.
  assign ilk = (G_LOAD_ILK != 0) && load_hazard_i && x_load_i && !ilk_d0_reg
               && !kill_o[G_ILK_STAGE] && !req_stall;
  assign bubble_o = ilk;

  genvar gi;
  generate
    for (gi = 0; gi < G_NUM_STAGES; gi++) begin : g_stall
      if (gi < G_NUM_STAGES - 1) begin : g_active
        assign stall_o[gi] = (|stall_req_i[G_NUM_STAGES-1:gi]) | (ilk && (gi <= G_ILK_STAGE));
      end else begin : g_last
        assign stall_o[gi] = 1'b0;
      end
    end

    // Stage s stays killed while the branch sits anywhere in stages s+1..branch stage.
    for (gi = 0; gi < G_NUM_STAGES; gi++) begin : g_kill
      if (gi == 0) begin : g_first
        assign kill_o[gi] = branch_take_i;
      end else if (gi <= G_BRANCH_STAGE) begin : g_shadow
        assign kill_o[gi] = branch_take_i | (|hist_reg[gi-1:0]);
      end else begin : g_none
        assign kill_o[gi] = 1'b0;
      end
    end
  endgenerate

  assign hist_shift    = !stall_o[G_BRANCH_STAGE];
  assign branch_accept = branch_take_i && hist_shift;

  generate
    for (gi = 0; gi < G_BRANCH_STAGE; gi++) begin : g_hist
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          hist_reg[gi] <= 1'b0;
        end else if (hist_shift) begin
          if (gi == 0) begin
            hist_reg[gi] <= branch_take_i;
          end else begin
            hist_reg[gi] <= hist_reg[(gi > 0) ? gi - 1 : 0];
          end
        end
      end
    end
  endgenerate

  // Holding ilk_d0 across request stalls yields exactly one bubble once the stall drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ilk_d0_reg <= 1'b0;
    end else if (!req_stall) begin
      ilk_d0_reg <= ilk;
    end
  end

  rv_sat_counter #(.G_WIDTH(G_CNT_WIDTH)) u_cnt_stall (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cnt_clear_i),
    .inc_i  (req_stall),
    .value_o(cnt_stall_o)
  );

  rv_sat_counter #(.G_WIDTH(G_CNT_WIDTH)) u_cnt_branch (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cnt_clear_i),
    .inc_i  (branch_accept),
    .value_o(cnt_branch_o)
  );

  rv_sat_counter #(.G_WIDTH(G_CNT_WIDTH)) u_cnt_ilk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cnt_clear_i),
    .inc_i  (ilk),
    .value_o(cnt_ilk_o)
  );

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Directed bench for rv_pipe_ctrl; narrow counters so saturation is reachable.
module tb_rv_pipe_ctrl;
  localparam int NS = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] stall_req;
  logic          branch_take;
  logic          load_hazard;
  logic          x_load;
  logic          cnt_clear;
  logic [NS-1:0] stall;
  logic [NS-1:0] kill;
  logic          bubble;
  logic [CW-1:0] cnt_stall;
  logic [CW-1:0] cnt_branch;
  logic [CW-1:0] cnt_ilk;

  int n_assert = 0;
  int n_fail   = 0;

  rv_pipe_ctrl #(
    .G_NUM_STAGES  (NS),
    .G_BRANCH_STAGE(2),
    .G_ILK_STAGE   (1),
    .G_LOAD_ILK    (1),
    .G_CNT_WIDTH   (CW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_req_i  (stall_req),
    .branch_take_i(branch_take),
    .load_hazard_i(load_hazard),
    .x_load_i     (x_load),
    .cnt_clear_i  (cnt_clear),
    .stall_o      (stall),
    .kill_o       (kill),
    .bubble_o     (bubble),
    .cnt_stall_o  (cnt_stall),
    .cnt_branch_o (cnt_branch),
    .cnt_ilk_o    (cnt_ilk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall_req = '0; branch_take = 1'b0;
    load_hazard = 1'b0; x_load = 1'b0; cnt_clear = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) tick();
    chk("idle_stall", 32'(stall), 32'h0);
    chk("idle_kill", 32'(kill), 32'h0);
    chk("idle_bubble", 32'(bubble), 32'h0);
    chk("idle_cnt_stall", 32'(cnt_stall), 32'h0);
    chk("idle_cnt_branch", 32'(cnt_branch), 32'h0);
    chk("idle_cnt_ilk", 32'(cnt_ilk), 32'h0);

    // 2: single taken branch, no stalls
    branch_take = 1'b1; #1;
    chk("br_kill0", 32'(kill), 32'h7);
    tick(); branch_take = 1'b0; #1;
    chk("br_kill1", 32'(kill), 32'h6);
    tick(); #1;
    chk("br_kill2", 32'(kill), 32'h4);
    tick(); #1;
    chk("br_kill3", 32'(kill), 32'h0);
    chk("br_cnt", 32'(cnt_branch), 32'h1);

    // 3: writeback stall request for 3 cycles
    for (int i = 0; i < 3; i++) begin
      stall_req = 4'b1000; #1;
      chk("req_stall", 32'(stall), 32'h7);
      tick();
    end
    stall_req = '0; #1;
    chk("req_stall_off", 32'(stall), 32'h0);
    chk("req_cnt", 32'(cnt_stall), 32'h3);

    // 4: load-use hazard held 2 cycles -> one bubble
    load_hazard = 1'b1; x_load = 1'b1; #1;
    chk("ilk_bubble0", 32'(bubble), 32'h1);
    chk("ilk_stall0", 32'(stall), 32'h3);
    tick(); #1;
    chk("ilk_bubble1", 32'(bubble), 32'h0);
    chk("ilk_stall1", 32'(stall), 32'h0);
    tick();
    load_hazard = 1'b0; x_load = 1'b0; #1;
    chk("ilk_cnt", 32'(cnt_ilk), 32'h1);

    // 5: branch whose shadow is frozen by a 2-cycle writeback stall
    branch_take = 1'b1; #1;
    chk("frz_kill0", 32'(kill), 32'h7);
    tick();
    branch_take = 1'b0; stall_req = 4'b1000; #1;
    chk("frz_kill1", 32'(kill), 32'h6);
    tick(); #1;
    chk("frz_kill2", 32'(kill), 32'h6);
    tick();
    stall_req = '0; #1;
    chk("frz_kill3", 32'(kill), 32'h6);
    tick(); #1;
    chk("frz_kill4", 32'(kill), 32'h4);
    tick(); #1;
    chk("frz_kill5", 32'(kill), 32'h0);
    chk("frz_cnt_branch", 32'(cnt_branch), 32'h2);
    chk("frz_cnt_stall", 32'(cnt_stall), 32'h5);

    // 6: hazard and branch together -> kill wins, no bubble
    load_hazard = 1'b1; x_load = 1'b1; branch_take = 1'b1; #1;
    chk("hb_bubble", 32'(bubble), 32'h0);
    chk("hb_kill", 32'(kill), 32'h7);
    chk("hb_stall", 32'(stall), 32'h0);
    tick();
    load_hazard = 1'b0; x_load = 1'b0; branch_take = 1'b0;
    tick(); tick(); #1;
    chk("hb_cnt_ilk", 32'(cnt_ilk), 32'h1);
    chk("hb_cnt_branch", 32'(cnt_branch), 32'h3);

    // Saturation: stall counter 5 + 10 = 15 (all-ones), then holds
    stall_req = 4'b0001; #1;
    chk("fetch_stall", 32'(stall), 32'h1);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_max", 32'(cnt_stall), 32'hF);
    tick();
    chk("sat_hold", 32'(cnt_stall), 32'hF);
    cnt_clear = 1'b1; tick();
    cnt_clear = 1'b0;
    chk("clr_win", 32'(cnt_stall), 32'h0);
    chk("clr_branch", 32'(cnt_branch), 32'h0);
    tick();
    stall_req = '0;
    chk("post_clr_inc", 32'(cnt_stall), 32'h1);

    // Request stall during a pending hazard: bubble deferred, then exactly one
    load_hazard = 1'b1; x_load = 1'b1; stall_req = 4'b1000; #1;
    chk("def_bubble0", 32'(bubble), 32'h0);
    tick(); #1;
    chk("def_bubble1", 32'(bubble), 32'h0);
    tick();
    stall_req = '0; #1;
    chk("def_bubble2", 32'(bubble), 32'h1);
    chk("def_stall2", 32'(stall), 32'h3);
    tick(); #1;
    chk("def_bubble3", 32'(bubble), 32'h0);
    tick();
    load_hazard = 1'b0; x_load = 1'b0; #1;
    chk("def_cnt_ilk", 32'(cnt_ilk), 32'h1);

    // Reset in the middle of a branch shadow
    branch_take = 1'b1; tick();
    branch_take = 1'b0; rst = 1'b1; #1;
    chk("rst_kill_pre", 32'(kill), 32'h6);
    tick();
    rst = 1'b0; #1;
    chk("rst_kill_post", 32'(kill), 32'h0);
    chk("rst_cnt_stall", 32'(cnt_stall), 32'h0);
    chk("rst_cnt_ilk", 32'(cnt_ilk), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
